// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port between ALU (A) and load (B) writebacks.
// Optional forwarding of held entries to decode is enabled with `define WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iAValid,
  input  logic [ADDR_W-1:0]    iARdAddr,
  input  logic [DATA_W-1:0]    iAData,
  output logic                 oAReady,
  input  logic                 iBValid,
  input  logic [ADDR_W-1:0]    iBRdAddr,
  input  logic [DATA_W-1:0]    iBData,
  output logic                 oBReady,
  output logic                 oWriteEn,
  output logic [ADDR_W-1:0]    oRdAddr,
  output logic [DATA_W-1:0]    oWriteData,
  output logic [2**ADDR_W-1:0] oPendingMask
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]    iRs1Addr,
  input  logic [ADDR_W-1:0]    iRs2Addr,
  output logic                 oRs1Hit,
  output logic                 oRs2Hit,
  output logic [DATA_W-1:0]    oRs1Data,
  output logic [DATA_W-1:0]    oRs2Data
`endif
);
  logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic              a_old_q, a_old_d, ptr_q, ptr_d;
  logic              same, grant_a, grant_b, a_load, b_load, a_keep, b_keep;
  // a_old_q: A is the older entry when both are held; ptr_q: 0 favours A, 1 favours B
  always_comb begin
    same         = a_vld_q & b_vld_q & (a_addr_q == b_addr_q);
    grant_a      = a_vld_q & (~b_vld_q | (same ? a_old_q : ~ptr_q));
    grant_b      = b_vld_q & ~grant_a;
    oAReady      = ~iRst & (~a_vld_q | grant_a);
    oBReady      = ~iRst & (~b_vld_q | grant_b);
    a_load       = iAValid & oAReady & (iARdAddr != '0);
    b_load       = iBValid & oBReady & (iBRdAddr != '0);
    a_keep       = a_vld_q & ~grant_a;
    b_keep       = b_vld_q & ~grant_b;
    a_vld_d      = a_load | a_keep;
    b_vld_d      = b_load | b_keep;
    a_addr_d     = a_load ? iARdAddr : a_addr_q;
    b_addr_d     = b_load ? iBRdAddr : b_addr_q;
    a_data_d     = a_load ? iAData : a_data_q;
    b_data_d     = b_load ? iBData : b_data_q;
    a_old_d      = (a_keep & b_keep) ? a_old_q : ~(b_keep & a_load);
    ptr_d        = (a_vld_q & b_vld_q & ~same) ? grant_a : ptr_q;
    oWriteEn     = grant_a | grant_b;
    oRdAddr      = grant_a ? a_addr_q : grant_b ? b_addr_q : '0;
    oWriteData   = grant_a ? a_data_q : grant_b ? b_data_q : '0;
    oPendingMask = '0;
    if (a_vld_q) oPendingMask[a_addr_q] = 1'b1;
    if (b_vld_q) oPendingMask[b_addr_q] = 1'b1;
  end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      a_old_q  <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_old_q  <= a_old_d;
      ptr_q    <= ptr_d;
    end
  end
`ifdef WB_FWD_EN
  logic h1a, h1b, h2a, h2b;
  // when both entries match, the younger one holds the newest value
  always_comb begin
    h1a      = a_vld_q & (a_addr_q == iRs1Addr) & (iRs1Addr != '0);
    h1b      = b_vld_q & (b_addr_q == iRs1Addr) & (iRs1Addr != '0);
    h2a      = a_vld_q & (a_addr_q == iRs2Addr) & (iRs2Addr != '0);
    h2b      = b_vld_q & (b_addr_q == iRs2Addr) & (iRs2Addr != '0);
    oRs1Hit  = h1a | h1b;
    oRs2Hit  = h2a | h2b;
    oRs1Data = (h1b & (~h1a | a_old_q)) ? b_data_q : h1a ? a_data_q : '0;
    oRs2Data = (h2b & (~h2a | a_old_q)) ? b_data_q : h2a ? a_data_q : '0;
  end
`endif
endmodule
